// File: rtl/alias_loop_checker_if.sv
// Handshake/data bundle between the alias checker and the fabric it drives and observes.
interface alias_loop_checker_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] drv_o;
  logic [WIDTH-1:0] obs_b;
  logic [WIDTH-1:0] obs_c;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       err_count;
  logic [15:0]      first_err_idx;

  modport master (
    output start, obs_b, obs_c,
    input  drv_o, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    input  start, obs_b, obs_c,
    output drv_o, busy, done, pass, err_count, first_err_idx
  );
endinterface

// File: rtl/alias_loop_checker.sv
// Drives a rotate/XOR vector sequence onto alias net a and checks ends b and c against a
// delayed copy, reporting pass/fail, a saturating error count and the first failing index.
module alias_loop_checker #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned NUM_VECTORS = 16,
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] SEED        = 32'hdeadbeef
) (
  input logic                 clk,
  input logic                 rst,
  alias_loop_checker_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  typedef struct packed {
    logic             valid;
    logic [15:0]      k;
    logic [WIDTH-1:0] vec;
  } pipe_t;

  localparam logic [WIDTH-1:0] SeedW     = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] XorMask   = {{(WIDTH - 8){1'b0}}, 8'hA5};
  localparam logic [15:0]      LastK     = 16'(NUM_VECTORS - 1);
  localparam logic [3:0]       DrainLast = 4'(LATENCY - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic             w_start_run;
  logic             w_busy;
  logic             w_done;
  logic             w_pass;
  logic             w_mismatch;
  logic [WIDTH-1:0] w_vec_next;
  logic [WIDTH-1:0] r_drv;
  logic             r_drv_valid;
  logic [15:0]      r_drv_k;
  logic [3:0]       r_drain_cnt;
  pipe_t            r_pipe [LATENCY];
  pipe_t            w_head;
  logic [7:0]       r_err_count;
  logic [15:0]      r_first_err_idx;

  assign w_start_run = bus.start && (r_state == StIdle || r_state == StDone);
  assign w_vec_next  = {r_drv[WIDTH-2:0], r_drv[WIDTH-1]} ^ XorMask;
  assign w_head      = r_pipe[LATENCY-1];
  // A mismatch on both ends is a single failing compare cycle.
  assign w_mismatch  = w_head.valid && ((bus.obs_b != w_head.vec) || (bus.obs_c != w_head.vec));

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: if (bus.start) w_state_next = StRun;
      StRun:          if (r_drv_k == LastK) w_state_next = StDrain;
      StDrain:        if (r_drain_cnt == '0) w_state_next = StDone;
      default:        w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_busy = (r_state == StRun) || (r_state == StDrain);
    w_done = (r_state == StDone);
    w_pass = (r_state == StDone) && (r_err_count == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drv           <= '0;
      r_drv_valid     <= 1'b0;
      r_drv_k         <= '0;
      r_drain_cnt     <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
    end else begin
      if (w_start_run) begin
        r_drv       <= SeedW;
        r_drv_valid <= 1'b1;
        r_drv_k     <= '0;
      end else if (r_state == StRun && r_drv_k != LastK) begin
        r_drv   <= w_vec_next;
        r_drv_k <= r_drv_k + 16'd1;
      end else begin
        r_drv       <= '0;
        r_drv_valid <= 1'b0;
        r_drv_k     <= '0;
      end

      if (r_state == StRun)        r_drain_cnt <= DrainLast;
      else if (r_state == StDrain) r_drain_cnt <= r_drain_cnt - 4'd1;

      // Stage 0 tracks what sits on drv_o now; the head lines up with obs_b/obs_c.
      r_pipe[0] <= '{valid: r_drv_valid, k: r_drv_k, vec: r_drv};
      for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];

      if (w_start_run) begin
        r_err_count     <= '0;
        r_first_err_idx <= '0;
      end else if (w_mismatch) begin
        if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        if (r_err_count == '0)    r_first_err_idx <= w_head.k;
      end
    end
  end

  assign bus.drv_o         = r_drv;
  assign bus.busy          = w_busy;
  assign bus.done          = w_done;
  assign bus.pass          = w_pass;
  assign bus.err_count     = r_err_count;
  assign bus.first_err_idx = r_first_err_idx;
endmodule
